// File: rtl/register_file_param.sv
// Parametrised register file: two combinational read ports, one write port, optional hardwired-zero R0
// and a one-register-per-cycle bulk-clear sweep. Optional write-through read bypass under RF_BYPASS_EN.
module register_file_param #(
    parameter int WIDTH   = 24,
    parameter int ADDR_W  = 4,
    parameter int R0_ZERO = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [ADDR_W-1:0] RD,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    input  logic              Clear,
    output logic [WIDTH-1:0]  ReadRS,
    output logic [WIDTH-1:0]  ReadRT,
    output logic              Busy,
    output logic              StateDbg
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] clrIdx;
    logic [ADDR_W-1:0] clrIdxNext;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              writeEn;

    // Clear/Busy protocol: Clear is a request sampled in IDLE only; Busy is high for exactly DEPTH
    // cycles while the sweep runs. Writes presented while Busy are dropped, so the caller must stall.
    assign Busy     = (state == CLEAR);
    assign StateDbg = state;
    assign writeEn  = RegWrite && !Busy && !((R0_ZERO != 0) && (RD == '0));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            clrIdx <= '0;
        end else begin
            state  <= stateNext;
            clrIdx <= clrIdxNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrIdxNext = clrIdx;
        case (state)
            IDLE: begin
                if (Clear) begin
                    stateNext  = CLEAR;
                    clrIdxNext = '0;
                end
            end
            CLEAR: begin
                clrIdxNext = clrIdx + 1'b1;
                if (clrIdx == '1) begin
                    stateNext  = IDLE;
                    clrIdxNext = '0;
                end
            end
            default: begin
                stateNext  = IDLE;
                clrIdxNext = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[clrIdx] <= '0;
        end else if (writeEn) begin
            regs[RD] <= WriteData;
        end
    end

    // Address 0 reads as zero when hardwired, regardless of stored contents or bypass.
    always_comb begin
        ReadRS = regs[RS];
`ifdef RF_BYPASS_EN
        if (writeEn && (RS == RD)) begin
            ReadRS = WriteData;
        end
`endif
        if ((R0_ZERO != 0) && (RS == '0)) begin
            ReadRS = '0;
        end
    end

    always_comb begin
        ReadRT = regs[RT];
`ifdef RF_BYPASS_EN
        if (writeEn && (RT == RD)) begin
            ReadRT = WriteData;
        end
`endif
        if ((R0_ZERO != 0) && (RT == '0)) begin
            ReadRT = '0;
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param (default parameters); expectations follow RF_BYPASS_EN if defined.
module tb_register_file_param;
    localparam int W = 24;
    localparam int A = 4;
`ifdef RF_BYPASS_EN
    localparam logic [W-1:0] BYP_EXP = 24'd8;
`else
    localparam logic [W-1:0] BYP_EXP = 24'd1;
`endif

    logic         Clock;
    logic         Reset;
    logic [A-1:0] RS, RT, RD;
    logic [W-1:0] WriteData;
    logic         RegWrite, Clear;
    logic [W-1:0] ReadRS, ReadRT;
    logic         Busy, StateDbg;

    int checks = 0;
    int errors = 0;
    int n;

    register_file_param dut (
        .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD),
        .WriteData(WriteData), .RegWrite(RegWrite), .Clear(Clear),
        .ReadRS(ReadRS), .ReadRT(ReadRT), .Busy(Busy), .StateDbg(StateDbg)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [A-1:0] addr, input logic [W-1:0] data);
        RD = addr;
        WriteData = data;
        RegWrite = 1'b1;
        step();
        RegWrite = 1'b0;
    endtask

    // Counts further busy cycles until Busy drops; bounded so a stuck sweep still reaches the summary.
    task automatic finish_sweep(input int start, output int cnt);
        cnt = start;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!Busy) break;
            cnt++;
        end
    endtask

    initial begin
        Reset = 1'b1; RS = '0; RT = '0; RD = '0; WriteData = '0; RegWrite = 1'b0; Clear = 1'b0;
        #12;
        Reset = 1'b0;
        RS = 4'd3; RT = 4'd15;
        #1;
        check("reset_rs", ReadRS, 24'd0);
        check("reset_rt", ReadRT, 24'd0);
        check("reset_busy", {23'd0, Busy}, 24'd0);
        check("reset_state", {23'd0, StateDbg}, 24'd0);

        // basic writes
        write_reg(4'd6, 24'd3);
        write_reg(4'd7, 24'd5);
        RS = 4'd6; RT = 4'd7;
        #1;
        check("wr_rs6", ReadRS, 24'd3);
        check("wr_rt7", ReadRT, 24'd5);

        // hardwired R0
        write_reg(4'd0, 24'hABCDEF);
        RS = 4'd0; RT = 4'd0;
        #1;
        check("r0_rs", ReadRS, 24'd0);
        check("r0_rt", ReadRT, 24'd0);

        // bypass behaviour, then post-edge visibility
        write_reg(4'd4, 24'd1);
        RS = 4'd4; RT = 4'd4; RD = 4'd4; WriteData = 24'd8; RegWrite = 1'b1;
        #1;
        check("byp_pre_rs", ReadRS, BYP_EXP);
        check("byp_pre_rt", ReadRT, BYP_EXP);
        step();
        RegWrite = 1'b0;
        check("byp_post_rs", ReadRS, 24'd8);

        // bulk clear with mid-sweep reads, ignored re-request and a discarded write
        write_reg(4'd5, 24'd9);
        write_reg(4'd12, 24'd4);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        check("sweep_busy", {23'd0, Busy}, 24'd1);
        check("sweep_state", {23'd0, StateDbg}, 24'd1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (n == 4) begin
                RS = 4'd5;
                #1;
                check("mid_r5_old", ReadRS, 24'd9);
                Clear = 1'b1;
            end else begin
                Clear = 1'b0;
            end
            if (n == 7) begin
                RS = 4'd5; RT = 4'd12;
                #1;
                check("mid_r5_clr", ReadRS, 24'd0);
                check("mid_r12_old", ReadRT, 24'd4);
            end
            if (n == 10) begin
                RD = 4'd2; WriteData = 24'd7; RegWrite = 1'b1;
            end else begin
                RegWrite = 1'b0;
            end
            step();
            if (!Busy) break;
            n++;
        end
        Clear = 1'b0; RegWrite = 1'b0;
        check("sweep_len", n, 16);
        RS = 4'd5; RT = 4'd12;
        #1;
        check("post_r5", ReadRS, 24'd0);
        check("post_r12", ReadRT, 24'd0);
        RS = 4'd2; RT = 4'd4;
        #1;
        check("post_r2_dropped", ReadRS, 24'd0);
        check("post_r4", ReadRT, 24'd0);
        check("post_busy", {23'd0, Busy}, 24'd0);

        // same-edge write and clear: write lands, sweep then zeroes it
        RD = 4'd9; WriteData = 24'h000123; RegWrite = 1'b1; Clear = 1'b1;
        step();
        RegWrite = 1'b0; Clear = 1'b0;
        RS = 4'd9;
        #1;
        check("same_edge_wr", ReadRS, 24'h000123);
        check("same_edge_busy", {23'd0, Busy}, 24'd1);
        finish_sweep(1, n);
        check("same_edge_len", n, 16);
        check("same_edge_clr", ReadRS, 24'd0);

        // async reset mid-sweep
        write_reg(4'd3, 24'h000077);
        write_reg(4'd10, 24'h00AAAA);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        step(); step(); step();
        #2;
        Reset = 1'b1;
        #1;
        RS = 4'd3; RT = 4'd10;
        #1;
        check("rst_busy", {23'd0, Busy}, 24'd0);
        check("rst_r3", ReadRS, 24'd0);
        check("rst_r10", ReadRT, 24'd0);
        #1;
        Reset = 1'b0;
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        finish_sweep(1, n);
        check("fresh_len", n, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
